// File: rtl/usr_seq.sv
// usr_seq: command sequencer that loads, shifts and captures a universal shift register
module usr_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [1:0]       usr_mode,
    output logic [WIDTH-1:0] usr_data,
    input  logic [WIDTH-1:0] usr_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_CAPTURE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_data, r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir, r_done;
    logic             w_accept;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid && !abort;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign usr_data  = r_data;
    assign done      = r_done;
    assign result    = r_result;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state and USR mode decode; abort returns to IDLE from any busy state
    always_comb begin
        w_next   = r_state;
        usr_mode = 2'b00;
        case (r_state)
            S_IDLE:    w_next = w_accept ? S_LOAD : S_IDLE;
            S_LOAD: begin
                usr_mode = 2'b11;
                w_next   = abort ? S_IDLE : (r_cnt != '0 ? S_SHIFT : S_CAPTURE);
            end
            S_SHIFT: begin
                usr_mode = r_dir ? 2'b10 : 2'b01;
                w_next   = abort ? S_IDLE : (r_cnt == CNT_W'(1) ? S_CAPTURE : S_SHIFT);
            end
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // command latch, shift countdown and result capture with done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_CAPTURE) && !abort;
            if (w_accept) begin
                r_data <= cmd_data;
                r_dir  <= cmd_dir;
                r_cnt  <= cmd_count;
            end else if (r_state == S_SHIFT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_state == S_CAPTURE && !abort) r_result <= usr_q;
        end
    end
endmodule

// File: doc/usr_seq.md
Name: usr_seq

Overview:
Sequencer for the team's 4-bit universal shift register (USR). It accepts a command word over a valid/ready handshake: load value, shift direction and shift count. It then drives the USR mode select and parallel-load data cycle by cycle, and captures the final register contents as a result with a one-cycle done pulse. It sits between a requester (CPU-side logic or testbench) and a USR instance in the Counters area.

Parameters:
WIDTH, 4, data width of the USR being sequenced
CNT_W, 3, width of shift-count field (max shift count 2^CNT_W-1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  requester has a command
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_data  input  WIDTH  value to parallel-load into USR
cmd_dir  input  1  0 = shift up (toward MSB, LSB fill 0); 1 = shift down (toward LSB, MSB fill 0)
cmd_count  input  CNT_W  number of shift cycles after load
abort  input  1  synchronous abort of current command
usr_mode  output  2  USR select: 00 hold, 01 shift up, 10 shift down, 11 parallel load
usr_data  output  WIDTH  USR parallel-load input
usr_q  input  WIDTH  USR register outputs
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse: result valid/updated
result  output  WIDTH  captured USR value of last completed command

Behaviour:
- Reset (async, active-high): state IDLE; usr_mode=00; usr_data=0; result=0; done=0; busy=0; internal count/dir cleared. cmd_ready=1 whenever state is IDLE, including while reset is held.
- Handshake: command accepted on a rising edge with cmd_valid&cmd_ready. cmd_data, cmd_dir and cmd_count are registered only at acceptance. Input changes at other times are ignored. cmd_valid outside IDLE has no effect.
- FSM states: IDLE, LOAD, SHIFT, CAPTURE.
- IDLE: usr_mode=00. On accept -> LOAD.
- LOAD (1 cycle): usr_mode=11, usr_data=latched cmd_data. Next state is SHIFT if count!=0, else CAPTURE.
- SHIFT: usr_mode=01 (dir 0) or 10 (dir 1). Remaining count decrements each cycle. Stays exactly count cycles, then -> CAPTURE.
- CAPTURE (1 cycle): usr_mode=00. On the edge: result<=usr_q, done<=1, -> IDLE.
- done is registered. It is high for exactly the first IDLE cycle after CAPTURE and low otherwise.
- Latency: with acceptance at edge E0, done is high in cycle E0+N+3, where N = cmd_count. cmd_ready is high in that same cycle, so back-to-back commands lose no cycle.
- usr_data holds the last loaded value outside LOAD. It only matters when usr_mode=11.
- Shift count beyond WIDTH is legal. The register drains to 0 and no saturation logic is needed.
- abort, high in LOAD/SHIFT/CAPTURE: next edge -> IDLE, usr_mode=00, no done, result unchanged. The USR keeps its partial value. abort in IDLE has no effect and takes priority over a simultaneous accept (no accept while abort=1).
- Reset mid-command: immediate return to reset values. No done is issued for the interrupted command.
- usr_mode is only ever 00 in IDLE/CAPTURE. It never takes a value outside the encoding above.

Test Plan:
- Load 4'b1011, dir=0, count=1 (bench USR attached) -> usr_mode sequence 11,01,00; done at E0+4; result=4'b0110.
- Load 4'b1011, dir=1, count=2 -> modes 11,10,10,00; done at E0+5; result=4'b0010.
- count=0, data 4'b1011 -> modes 11,00; done at E0+3; result=4'b1011. count=7, dir=0, data 4'b1111 -> result=4'b0000, done at E0+10.
- cmd_valid held high with two commands (1011/up/1 then 0001/up/3) -> second accepted in the done cycle of the first; results 0110 then 1000; no idle gap.
- abort asserted during 2nd SHIFT cycle of a count=5 command -> next cycle IDLE, usr_mode=00, no done, result keeps its prior value; a new command then completes normally.
- reset pulsed mid-SHIFT (asynchronously, between edges) -> outputs immediately at reset values, busy=0, cmd_ready=1, no done after release.
